// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants, FSM state type and step function for the
// LFSR round-robin scheduler. No ports.
package lfsr_pkg;

    localparam int          LFSR_W        = 5;
    localparam logic [4:0]  LFSR_RST_SEED = 5'b11111;
    localparam int          TAP_HI        = 5;
    localparam int          TAP_LO        = 2;
    localparam int          LFSR_PERIOD   = 31;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // {s5..s1} -> {s4..s1, s5^s2}
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        return {s[LFSR_W-2:0], s[TAP_HI-1] ^ s[TAP_LO-1]};
    endfunction

endpackage

// File: rtl/lfsr_rr_scheduler_if.sv
// lfsr_rr_scheduler_if: requester-side bundle of the scheduler.
// master: req/seed_load/seed_in out; gnt/rvalid/rdata/busy/lfsr_state
// (and wrap when LFSR_WRAP_FLAG_EN is defined) in. slave: mirror image.
interface lfsr_rr_scheduler_if
    import lfsr_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int N_REQ  = 2
);
    logic [N_REQ-1:0]  req;
    logic              seed_load;
    logic [LFSR_W-1:0] seed_in;
    logic [N_REQ-1:0]  gnt;
    logic [N_REQ-1:0]  rvalid;
    logic [WORD_W-1:0] rdata;
    logic              busy;
    logic [LFSR_W-1:0] lfsr_state;
`ifdef LFSR_WRAP_FLAG_EN
    logic              wrap;
`endif

    modport master (
`ifdef LFSR_WRAP_FLAG_EN
        input  wrap,
`endif
        output req, seed_load, seed_in,
        input  gnt, rvalid, rdata, busy, lfsr_state
    );

    modport slave (
`ifdef LFSR_WRAP_FLAG_EN
        output wrap,
`endif
        input  req, seed_load, seed_in,
        output gnt, rvalid, rdata, busy, lfsr_state
    );

endinterface

// File: rtl/lfsr_rr_scheduler_core.sv
// lfsr_core: 5-bit Fibonacci LFSR (s1 <= s5^s2) with load and zero guard.
// Ports: clk, rst, step_en, load_en, load_val in; state, out_bit (=s5) out.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_RST = LFSR_RST_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_en,
    input  logic              load_en,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state,
    output logic              out_bit
);
    logic [LFSR_W-1:0] s;

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= SEED_RST;
        end else if (load_en) begin
            // all-zero is the lock-up state; substitute the default seed
            s <= (load_val == '0) ? LFSR_RST_SEED : load_val;
        end else if (step_en) begin
            s <= lfsr_next(s);
        end
    end

    assign state   = s;
    assign out_bit = s[LFSR_W-1];

endmodule

// File: rtl/lfsr_rr_scheduler.sv
// lfsr_rr_scheduler: round-robin share of one LFSR; each grant packs
// WORD_W output bits MSB-first into rdata and pulses rvalid.
// Ports: clk, rst (sync, active-high), bus (lfsr_rr_scheduler_if.slave).
// Optional: LFSR_WRAP_FLAG_EN adds bus.wrap, a full-period pulse.
module lfsr_rr_scheduler
    import lfsr_pkg::*;
#(
    parameter int                WORD_W   = 8,
    parameter int                N_REQ    = 2,
    parameter logic [LFSR_W-1:0] SEED_RST = LFSR_RST_SEED
) (
    input  logic                clk,
    input  logic                rst,
    lfsr_rr_scheduler_if.slave  bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(WORD_W + 1);

    state_e            state, nxt;
    logic [IDX_W-1:0]  ptr, idx, pick;
    logic              found;
    logic [CNT_W-1:0]  cnt;
    logic [N_REQ-1:0]  gnt_q;
    logic [WORD_W-1:0] rdata_q;
    logic              step_en, load_en, out_bit;
    logic [LFSR_W-1:0] lstate;

    lfsr_core #(.SEED_RST(SEED_RST)) u_core (
        .clk      (clk),
        .rst      (rst),
        .step_en  (step_en),
        .load_en  (load_en),
        .load_val (bus.seed_in),
        .state    (lstate),
        .out_bit  (out_bit)
    );

    // first requester at or above ptr, wrapping
    always_comb begin
        int c;
        c     = 0;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= N_REQ) c = c - N_REQ;
            if (!found && bus.req[c]) begin
                found = 1'b1;
                pick  = IDX_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (!bus.seed_load && found) nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(WORD_W - 1)) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        step_en    = (state == SHIFT);
        load_en    = (state == IDLE) && bus.seed_load;
        bus.busy   = (state != IDLE);
        bus.rvalid = (state == DONE) ? gnt_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            idx     <= '0;
            cnt     <= '0;
            gnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!bus.seed_load && found) begin
                        idx   <= pick;
                        gnt_q <= N_REQ'(1) << pick;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    rdata_q <= WORD_W'({rdata_q, out_bit});
                    cnt     <= cnt + CNT_W'(1);
                end
                DONE: begin
                    gnt_q <= '0;
                    ptr   <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef LFSR_WRAP_FLAG_EN
    logic [LFSR_W-1:0] wcnt;
    logic              wrap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt   <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (load_en) begin
                wcnt <= '0;
            end else if (step_en) begin
                if (wcnt == LFSR_W'(LFSR_PERIOD - 1)) begin
                    wcnt   <= '0;
                    wrap_q <= 1'b1;
                end else begin
                    wcnt <= wcnt + LFSR_W'(1);
                end
            end
        end
    end

    assign bus.wrap = wrap_q;
`endif

    assign bus.gnt        = gnt_q;
    assign bus.rdata      = rdata_q;
    assign bus.lfsr_state = lstate;

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// tb_lfsr_rr_scheduler: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed words.
module tb_lfsr_rr_scheduler;

    localparam int W = 8;
    localparam int N = 2;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_rr_scheduler_if #(.WORD_W(W), .N_REQ(N)) bus();

    lfsr_rr_scheduler #(
        .WORD_W   (W),
        .N_REQ    (N),
        .SEED_RST (5'h1F)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit armed    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // model: a transaction owner, remaining shift count and done flag
    int m_lfsr  = 31;
    int m_ptr   = 0;
    int m_left  = 0;
    int m_owner = -1;
    int m_word  = 0;
    int m_steps = 0;
    bit m_done  = 0;
    bit m_wrap  = 0;

    always @(posedge clk) begin
        int o;
        m_wrap = 0;
        if (rst) begin
            m_lfsr = 31; m_ptr = 0; m_left = 0; m_owner = -1;
            m_word = 0; m_steps = 0; m_done = 0;
        end else if (m_done) begin
            m_done  = 0;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (m_left > 0) begin
            o      = (m_lfsr / 16) % 2;
            m_word = (m_word * 2 + o) & MASK;
            m_lfsr = ((m_lfsr * 2) % 32) + (o ^ ((m_lfsr / 2) % 2));
            m_steps++;
            if (m_steps == 31) begin
                m_steps = 0;
                m_wrap  = 1;
            end
            m_left--;
            if (m_left == 0) m_done = 1;
        end else if (bus.seed_load) begin
            m_lfsr  = (bus.seed_in == 0) ? 31 : int'(bus.seed_in);
            m_steps = 0;
        end else if (bus.req != 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && bus.req[(m_ptr + k) % N])
                    m_owner = (m_ptr + k) % N;
            end
            m_left = W;
        end
    end

    int ev_rv[$];
    int ev_dat[$];
    int wraps     = 0;
    int wrap_lfsr = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("gnt", bus.gnt, (m_owner >= 0) ? (1 << m_owner) : 0);
            chk("rvalid", bus.rvalid, m_done ? (1 << m_owner) : 0);
            chk("busy", bus.busy, (m_owner >= 0) ? 1 : 0);
            chk("rdata", bus.rdata, m_word);
            chk("lfsr_state", bus.lfsr_state, m_lfsr);
`ifdef LFSR_WRAP_FLAG_EN
            chk("wrap", bus.wrap, m_wrap);
            if (bus.wrap) begin
                wraps++;
                wrap_lfsr = bus.lfsr_state;
            end
`endif
            if (bus.rvalid != 0) begin
                ev_rv.push_back(bus.rvalid);
                ev_dat.push_back(bus.rdata);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.seed_load = 1'b0;
        bus.seed_in = '0;
        @(negedge clk);
        armed = 1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_rv(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.rvalid == 0 && n < 40);
        chk("rvalid_seen", bus.rvalid != 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_seen", bus.busy, 0);
    endtask

    initial begin
        int n;

        // 1: reset values, latency, first word
        do_reset();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_lfsr", bus.lfsr_state, 5'h1F);
        bus.req = 2'b01;
        @(negedge clk);
        chk("t1_gnt", bus.gnt, 2'b01);
        wait_rv(n);
        bus.req = 2'b00;
        chk("t1_latency", n + 1, 9);
        chk("t1_rvalid", bus.rvalid, 2'b01);
        chk("t1_rdata", bus.rdata, 8'hF9);
        chk("t1_lfsr", bus.lfsr_state, 5'h14);

        // 2: both requesting, strict alternation
        do_reset();
        ev_rv.delete();
        ev_dat.delete();
        bus.req = 2'b11;
        n = 0;
        while (ev_rv.size() < 4 && n < 60) begin
            @(negedge clk);
            n++;
        end
        bus.req = 2'b00;
        chk("t2_events", ev_rv.size(), 4);
        if (ev_rv.size() >= 4) begin
            chk("t2_who0", ev_rv[0], 1);
            chk("t2_who1", ev_rv[1], 2);
            chk("t2_who2", ev_rv[2], 1);
            chk("t2_who3", ev_rv[3], 2);
            chk("t2_dat0", ev_dat[0], 8'hF9);
            chk("t2_dat1", ev_dat[1], 8'hA4);
        end
        wait_idle();

        // 3: zero seed guard, seed_load ignored while busy
        bus.seed_load = 1'b1;
        bus.seed_in = 5'h00;
        @(negedge clk);
        bus.seed_load = 1'b0;
        chk("t3_seed0", bus.lfsr_state, 5'h1F);
        chk("t3_gnt0", bus.gnt, 0);
        bus.req = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        chk("t3_busy", bus.busy, 1);
        repeat (3) @(negedge clk);
        bus.seed_load = 1'b1;
        bus.seed_in = 5'h0A;
        @(negedge clk);
        bus.seed_load = 1'b0;
        wait_rv(n);
        chk("t3_rdata", bus.rdata, 8'hF9);
        chk("t3_lfsr", bus.lfsr_state, 5'h14);

        // 4a: req dropped after grant still completes
        do_reset();
        bus.req = 2'b01;
        @(negedge clk);
        chk("t4_gnt", bus.gnt, 2'b01);
        bus.req = 2'b00;
        wait_rv(n);
        chk("t4_rvalid", bus.rvalid, 2'b01);
        chk("t4_rdata", bus.rdata, 8'hF9);

        // 4b: reset in the 4th SHIFT cycle aborts silently
        do_reset();
        ev_rv.delete();
        bus.req = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4b_lfsr", bus.lfsr_state, 5'h1F);
        chk("t4b_busy", bus.busy, 0);
        chk("t4b_gnt", bus.gnt, 0);
        repeat (12) @(negedge clk);
        chk("t4b_no_rv", ev_rv.size(), 0);
        bus.req = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        wait_rv(n);
        chk("t4b_rdata", bus.rdata, 8'hF9);

        // 5: seed_load wins over req in the same cycle
        do_reset();
        bus.seed_load = 1'b1;
        bus.seed_in = 5'h0A;
        bus.req = 2'b01;
        @(negedge clk);
        bus.seed_load = 1'b0;
        chk("t5_gnt0", bus.gnt, 0);
        chk("t5_lfsr", bus.lfsr_state, 5'h0A);
        @(negedge clk);
        bus.req = 2'b00;
        chk("t5_gnt1", bus.gnt, 2'b01);
        wait_rv(n);
        chk("t5_rdata", bus.rdata, 8'h57);
        chk("t5_lfsr_end", bus.lfsr_state, 5'h0C);

`ifdef LFSR_WRAP_FLAG_EN
        // 6: full period marker
        do_reset();
        ev_rv.delete();
        wraps = 0;
        bus.req = 2'b11;
        n = 0;
        while (ev_rv.size() < 4 && n < 60) begin
            @(negedge clk);
            n++;
        end
        bus.req = 2'b00;
        chk("t6_wraps", wraps, 1);
        chk("t6_wrap_lfsr", wrap_lfsr, 5'h1F);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_rr_scheduler.md
Name: lfsr_rr_scheduler

Overview:
Shares one 5-bit Fibonacci LFSR (feedback s1 <= s5 ^ s2, maximal length 31) among N_REQ requesters. Grants are round-robin. For each grant the block steps the LFSR WORD_W times and packs the output bits MSB-first into a word. The word is returned to the granted requester with a one-cycle valid pulse. It sits between the pseudo-random source and its consumers, such as test-pattern and scrambler clients.

Parameters:
WORD_W, 8, bits per returned word (LFSR steps per grant); legal range 1..16
N_REQ, 2, number of requesters; legal range 2..4
SEED_RST, 5'b11111, LFSR state after reset; must be nonzero

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request level
seed_load  in  1  load seed_in into the LFSR (honoured only in IDLE)
seed_in  in  5  seed value; bit i maps to s(i+1)
gnt  out  N_REQ  one-hot grant, registered
rvalid  out  N_REQ  one-cycle pulse on the granted requester's bit when rdata is valid
rdata  out  WORD_W  packed random word
busy  out  1  high in SHIFT and DONE
lfsr_state  out  5  current LFSR state {s5,s4,s3,s2,s1}

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, LFSR=SEED_RST, round-robin pointer=0.
  - gnt=0, rvalid=0, rdata=0, busy=0, shift counter=0.
  - Reset mid-transaction aborts it with no rvalid.
- LFSR step: the output bit is s5, sampled before the shift. Then s1<=s5^s2 and sk<=s(k-1) for k=2..5. The LFSR steps only in SHIFT.
- States:
  - IDLE:
    - seed_load=1 has priority over req. LFSR<=seed_in; if seed_in==0, load 5'b11111 instead. Stay in IDLE with no grant that cycle.
    - Otherwise, if any req is high, grant the first requesting index at or above the pointer, wrapping. gnt<=onehot(idx), counter<=0, go to SHIFT.
  - SHIFT:
    - Each cycle: rdata<={rdata[WORD_W-2:0], s5}, step the LFSR, counter++.
    - After WORD_W cycles, go to DONE.
  - DONE:
    - rvalid[idx]=1 for exactly this cycle. gnt is held until this cycle ends, then cleared.
    - pointer<=(idx+1) mod N_REQ, go to IDLE.
- Latency: a req sampled in IDLE at edge t gives gnt high from t+1, SHIFT in cycles t+1..t+WORD_W, and rvalid in cycle t+WORD_W+1. Minimum spacing between grants is WORD_W+2 cycles.
- rdata holds its last value until the next SHIFT begins. The rdata register is not cleared between grants; it is fully overwritten over the WORD_W shifts.
- req is a level. Dropping req after grant does not abort; the transaction completes and rvalid still pulses. A requester holding req high is re-granted only when the pointer reaches it again.
- seed_load while busy=1 is ignored, with no side effects.
- Simultaneous req from all requesters: strict round-robin, no starvation. Worst-case wait is (N_REQ-1)*(WORD_W+2) cycles.
- The LFSR never reaches the all-zero state; the seed guard above enforces this.

Optional Feature:
LFSR_WRAP_FLAG_EN
- When defined: add output wrap (1 bit) and an internal 5-bit step counter.
  - The counter resets to 0 on rst and on an accepted seed_load.
  - It increments on each LFSR step.
  - On the step that brings it to 31, wrap pulses for one cycle and the counter returns to 0. This marks a full period; lfsr_state then equals the value loaded at reset or seed_load.
- When undefined: no wrap port and no counter; all other behaviour is identical.

Decomposition:
- Package lfsr_pkg:
  - LFSR_W=5
  - LFSR_RST_SEED=5'b11111
  - tap constants (5, 2)
  - LFSR_PERIOD=31
  - state enum {IDLE, SHIFT, DONE}
- One sub-module, lfsr_core, holding the 5 state flops.
  - Inputs: clk, rst, step_en, load_en, load_val.
  - Outputs: state and out_bit (=s5).
  - lfsr_core applies the zero-seed guard.
- The scheduler keeps the FSM, arbiter, counter and packing register.

Test Plan:
1. Reset, then req=2'b01 only -> gnt=01 one cycle after the sampling edge; rvalid=01 exactly 9 cycles after the sampling edge; rdata=8'hF9; lfsr_state=5'h14.
2. Reset, then req=2'b11 held high -> requester 0 receives 8'hF9, then requester 1 receives 8'hA4; grant order continues 0,1,0,1.
3. In IDLE, seed_load=1, seed_in=5'h00 -> lfsr_state=5'h1F; next grant returns 8'hF9. Repeat with seed_in=5'h0A during SHIFT -> ignored, lfsr_state sequence undisturbed.
4. Assert req=2'b01, drop req the cycle after gnt -> rvalid still pulses with the full word. Separately, assert rst during cycle 4 of SHIFT -> no rvalid; lfsr_state=5'h1F; next word is 8'hF9.
5. seed_load and req both high in IDLE -> seed loaded, gnt stays 0 that cycle, grant starts the following cycle.
6. With LFSR_WRAP_FLAG_EN defined, run 31 consecutive steps from reset -> wrap pulses exactly once, on the 31st step, with lfsr_state=5'h1F.
